// File: rtl/la_seq_adder_ctrl.sv
// Sequential WIDTH-bit adder: one shared 4-bit CLA slice, one nibble per cycle, LSB first.
// Latency: out_valid rises NIB cycles after the operand accept edge; one op per NIB+2 cycles.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready is seen.
//
// Ports (la_seq_adder_ctrl):
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake carrying A, B, Cin
//   out_valid/ out_ready result handshake carrying Sum, Cout, Pout
//   busy                 high while an operation is in flight or awaiting handoff
// Ports (la_adder4): a_i, b_i, cin_i -> sum_o, cout_o, pout_o (group propagate)

module la_adder4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o,
   output logic       pout_o
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   // Carry lookahead: every carry is expressed directly in terms of cin_i.
   assign c[0] = cin_i;
   assign c[1] = g[0] | (p[0] & cin_i);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin_i);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin_i);

   assign sum_o  = p ^ c[3:0];
   assign cout_o = c[4];
   assign pout_o = &p;
endmodule

module la_seq_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Pout,
   output logic             busy
);
   localparam int NIB  = WIDTH / 4;
   // Keep the index at least 1 bit wide so WIDTH=4 still elaborates.
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

   localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             c_q;      // carry into the current nibble
   logic             p_q;      // running AND of nibble propagates
   logic [IDXW-1:0]  idx_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             pout_q;

   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [3:0]       s_nib;
   logic             co_nib;
   logic             po_nib;
   logic             last_nib;

   // Nibble base is idx*4, formed by appending two zero bits.
   assign a_nib    = a_q[{idx_q, 2'b00} +: 4];
   assign b_nib    = b_q[{idx_q, 2'b00} +: 4];
   assign last_nib = (idx_q == IDX_LAST);

   la_adder4 u_slice (
      .a_i    (a_nib),
      .b_i    (b_nib),
      .cin_i  (c_q),
      .sum_o  (s_nib),
      .cout_o (co_nib),
      .pout_o (po_nib)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid)  state_d = S_RUN;
         S_RUN:   if (last_nib)  state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default:                state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         p_q     <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         pout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q   <= A;
                  b_q   <= B;
                  c_q   <= Cin;
                  p_q   <= 1'b1;
                  idx_q <= '0;
               end
            end
            S_RUN: begin
               sum_q[{idx_q, 2'b00} +: 4] <= s_nib;
               c_q   <= co_nib;
               p_q   <= p_q & po_nib;
               idx_q <= idx_q + IDX_ONE;
               if (last_nib) begin
                  cout_q <= co_nib;
                  pout_q <= p_q & po_nib;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
   assign Sum       = sum_q;
   assign Cout      = cout_q;
   assign Pout      = pout_q;
endmodule

// File: tb/tb_la_seq_adder_ctrl.sv
// Directed and randomised bench for la_seq_adder_ctrl at WIDTH=16.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
// Results are compared against hand-computed constants and a reference add.

module tb_la_seq_adder_ctrl;
   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic        Cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] Sum;
   logic        Cout;
   logic        Pout;
   logic        busy;

   int n_chk;
   int n_err;
   int cyc;

   la_seq_adder_ctrl #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Sum       (Sum),
      .Cout      (Cout),
      .Pout      (Pout),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands for one edge (caller guarantees in_ready), then scramble the inputs.
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c);
      in_valid = 1'b1;
      A = a;
      B = b;
      Cin = c;
      tick();
      in_valid = 1'b0;
      A   = 16'($urandom);
      B   = 16'($urandom);
      Cin = 1'($urandom);
   endtask

   task automatic wait_ov(input string tag, output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk(tag, 32'(out_valid), 32'd1);
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int          lat;
      int          c1;
      int          c2;
      int          guard;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      logic [16:0] rexp;

      n_chk     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = 16'h0;
      B         = 16'h0;
      Cin       = 1'b0;

      // Reset state
      #2;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_sum",       32'(Sum),       32'h0);
      chk("rst_cout",      32'(Cout),      32'd0);
      chk("rst_pout",      32'(Pout),      32'd0);
      #20;
      rst_n = 1'b1;
      tick();

      // FFFF + 0001: carry out of the top nibble, latency exactly 4
      chk("t1_in_ready", 32'(in_ready), 32'd1);
      issue(16'hFFFF, 16'h0001, 1'b0);
      chk("t1_busy_run", 32'(busy), 32'd1);
      wait_ov("t1_ov", lat);
      chk("t1_latency", 32'(lat), 32'd4);
      chk("t1_sum",  32'(Sum),  32'h0000);
      chk("t1_cout", 32'(Cout), 32'd1);
      chk("t1_pout", 32'(Pout), 32'd0);
      chk("t1_in_ready_done", 32'(in_ready), 32'd0);
      handoff();
      chk("t1_ov_drop",   32'(out_valid), 32'd0);
      chk("t1_idle",      32'(in_ready),  32'd1);
      chk("t1_busy_idle", 32'(busy),      32'd0);
      chk("t1_sum_kept",  32'(Sum),       32'h0000);
      chk("t1_cout_kept", 32'(Cout),      32'd1);

      // 5555 + AAAA + 1: carry ripples across all four nibbles, full propagate
      issue(16'h5555, 16'hAAAA, 1'b1);
      wait_ov("t2_ov", lat);
      chk("t2_sum",  32'(Sum),  32'h0000);
      chk("t2_cout", 32'(Cout), 32'd1);
      chk("t2_pout", 32'(Pout), 32'd1);
      handoff();

      // 1234 + 4321 with a 5-cycle consumer stall and in_valid pulses while busy
      issue(16'h1234, 16'h4321, 1'b0);
      wait_ov("t3_ov", lat);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         A = 16'hFFFF;
         B = 16'hFFFF;
         tick();
         chk("t3_sum_hold",  32'(Sum),       32'h5555);
         chk("t3_ov_hold",   32'(out_valid), 32'd1);
         chk("t3_ready_low", 32'(in_ready),  32'd0);
      end
      in_valid = 1'b0;
      chk("t3_cout", 32'(Cout), 32'd0);
      chk("t3_pout", 32'(Pout), 32'd0);
      handoff();
      chk("t3_sum_after", 32'(Sum),      32'h5555);
      chk("t3_idle",      32'(in_ready), 32'd1);

      // Reset asserted mid-RUN (idx=2), then a fresh op
      out_ready = 1'b1;
      issue(16'hFFFF, 16'hFFFF, 1'b1);
      tick();
      tick();
      chk("t4_busy_before_rst", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t4_rst_sum",      32'(Sum),       32'h0);
      chk("t4_rst_cout",     32'(Cout),      32'd0);
      chk("t4_rst_pout",     32'(Pout),      32'd0);
      chk("t4_rst_in_ready", 32'(in_ready),  32'd1);
      chk("t4_rst_ov",       32'(out_valid), 32'd0);
      chk("t4_rst_busy",     32'(busy),      32'd0);
      #2;
      rst_n = 1'b1;
      out_ready = 1'b0;
      tick();
      issue(16'h0001, 16'h0001, 1'b0);
      wait_ov("t4_ov", lat);
      chk("t4_latency", 32'(lat), 32'd4);
      chk("t4_sum",  32'(Sum),  32'h0002);
      chk("t4_cout", 32'(Cout), 32'd0);
      handoff();

      // Back-to-back with in_valid and out_ready tied high
      in_valid  = 1'b1;
      out_ready = 1'b1;
      A = 16'h0000;
      B = 16'h0000;
      Cin = 1'b1;
      tick();
      c1 = cyc;
      A = 16'h8000;
      B = 16'h8000;
      Cin = 1'b0;
      wait_ov("t5_ov1", lat);
      chk("t5_sum1",  32'(Sum),  32'h0001);
      chk("t5_cout1", 32'(Cout), 32'd0);
      guard = 0;
      tick();
      while (!in_ready && guard < 10) begin
         tick();
         guard++;
      end
      chk("t5_ready_again", 32'(in_ready), 32'd1);
      tick();
      c2 = cyc;
      in_valid = 1'b0;
      chk("t5_accept_gap", 32'(c2 - c1), 32'd6);
      wait_ov("t5_ov2", lat);
      chk("t5_sum2",  32'(Sum),  32'h0000);
      chk("t5_cout2", 32'(Cout), 32'd1);
      chk("t5_pout2", 32'(Pout), 32'd0);
      tick();
      out_ready = 1'b0;

      // Random operands with random producer gaps and consumer stalls
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         chk("rnd_in_ready", 32'(in_ready), 32'd1);
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         rexp = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
         issue(ra, rb, rc);
         wait_ov("rnd_ov", lat);
         repeat ($urandom_range(0, 3)) tick();
         handoff();
         chk("rnd_sum_cout", 32'({Cout, Sum}), 32'(rexp));
         chk("rnd_pout",     32'(Pout),        32'(&(ra ^ rb)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
